// File: rtl/alu_multicycle.sv
// Multi-cycle execute unit: single-cycle ADD/SUB/logic/rotate, iterative shift-add MUL.
// Valid/ready on both sides; results are held in DONE until the consumer takes them.
module alu_multicycle #(
  parameter int WIDTH    = 16,
  parameter int MUL_STEP = 1
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_src1,
  input  logic [WIDTH-1:0] i_src2,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic [WIDTH-1:0] o_result_high,
  output logic             o_carry,
  output logic             o_zero
);

  // state | meaning
  // IDLE  | ready for a request
  // BUSY  | MUL iterating, one MUL_STEP slice of the multiplier per cycle
  // DONE  | result valid, held until i_ready
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam int STEPS = WIDTH / MUL_STEP;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int AW    = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;
  localparam logic [2:0] OP_ROL = 3'd6;
  localparam logic [2:0] OP_ROR = 3'd7;

  state_t state, state_nxt;

  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic [WIDTH:0]     sum, diff;
  logic [2*WIDTH-1:0] rol_t, ror_t;
  logic [AW-1:0]      amt;

  assign o_ready = (state == S_IDLE);
  assign o_valid = (state == S_DONE);

  always_ff @(posedge i_clock) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (i_valid) state_nxt = (i_op == OP_MUL) ? S_BUSY : S_DONE;
      S_BUSY: if (cnt == '0) state_nxt = S_DONE;
      S_DONE: if (i_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Single-cycle ops are evaluated straight off the request operands at accept.
  always_comb begin
    amt       = i_src2[AW-1:0];
    sum       = {1'b0, i_src1} + {1'b0, i_src2};
    diff      = {1'b0, i_src1} - {1'b0, i_src2};
    rol_t     = {i_src1, i_src1} << amt;
    ror_t     = {i_src1, i_src1} >> amt;
    alu_res   = '0;
    alu_carry = 1'b0;
    case (i_op)
      OP_ADD: begin alu_res = sum[WIDTH-1:0];  alu_carry = sum[WIDTH];  end
      OP_SUB: begin alu_res = diff[WIDTH-1:0]; alu_carry = diff[WIDTH]; end
      OP_AND: alu_res = i_src1 & i_src2;
      OP_OR:  alu_res = i_src1 | i_src2;
      OP_XOR: alu_res = i_src1 ^ i_src2;
      OP_ROL: alu_res = rol_t[2*WIDTH-1:WIDTH];
      OP_ROR: alu_res = ror_t[WIDTH-1:0];
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    acc_nxt = acc;
    for (int j = 0; j < MUL_STEP; j++) begin
      if (mplier[j]) acc_nxt = acc_nxt + (mcand << j);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      acc           <= '0;
      mcand         <= '0;
      mplier        <= '0;
      cnt           <= '0;
      o_result      <= '0;
      o_result_high <= '0;
      o_carry       <= 1'b0;
      o_zero        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_valid) begin
            if (i_op == OP_MUL) begin
              acc    <= '0;
              mcand  <= {{WIDTH{1'b0}}, i_src1};
              mplier <= i_src2;
              cnt    <= CW'(STEPS - 1);
            end else begin
              o_result      <= alu_res;
              o_result_high <= '0;
              o_carry       <= alu_carry;
              o_zero        <= (alu_res == '0);
            end
          end
        end
        S_BUSY: begin
          acc    <= acc_nxt;
          mcand  <= mcand << MUL_STEP;
          mplier <= mplier >> MUL_STEP;
          cnt    <= cnt - 1'b1;
          if (cnt == '0) begin
            o_result      <= acc_nxt[WIDTH-1:0];
            o_result_high <= acc_nxt[2*WIDTH-1:WIDTH];
            o_carry       <= 1'b0;
            o_zero        <= (acc_nxt[WIDTH-1:0] == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: vector table plus backpressure and mid-MUL reset sequences.
// Two instances (MUL_STEP=1 and 4) share the request/consumer inputs.
module tb_alu_multicycle;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid;
  logic [2:0]  op;
  logic [15:0] src1, src2;
  logic        rdy_in;

  logic        ready1, valid1, carry1, zero1;
  logic [15:0] res1, high1;
  logic        ready4, valid4, carry4, zero4;
  logic [15:0] res4, high4;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  alu_multicycle #(.WIDTH(16), .MUL_STEP(1)) dut1 (
    .i_clock(clock), .i_reset(reset), .i_valid(valid), .o_ready(ready1),
    .i_op(op), .i_src1(src1), .i_src2(src2), .o_valid(valid1), .i_ready(rdy_in),
    .o_result(res1), .o_result_high(high1), .o_carry(carry1), .o_zero(zero1)
  );

  alu_multicycle #(.WIDTH(16), .MUL_STEP(4)) dut4 (
    .i_clock(clock), .i_reset(reset), .i_valid(valid), .o_ready(ready4),
    .i_op(op), .i_src1(src1), .i_src2(src2), .o_valid(valid4), .i_ready(rdy_in),
    .o_result(res4), .o_result_high(high4), .o_carry(carry4), .o_zero(zero4)
  );

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [15:0] high;
    logic        carry;
    logic        zero;
    int          lat1;
    int          lat4;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Issue one request, wait for both instances, compare, then drain one edge.
  task automatic run_vec(input int idx, input vec_t v);
    int lat1, lat4;
    logic [15:0] r4, h4;
    logic c4, z4;
    lat1 = -1; lat4 = -1; r4 = '0; h4 = '0; c4 = 1'b0; z4 = 1'b0;
    op = v.op; src1 = v.a; src2 = v.b; valid = 1'b1;
    @(posedge clock); #1;
    valid = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (lat4 < 0 && valid4) begin
        lat4 = n; r4 = res4; h4 = high4; c4 = carry4; z4 = zero4;
      end
      if (valid1) begin
        lat1 = n;
        break;
      end
      @(posedge clock); #1;
    end
    chk($sformatf("v%0d_lat1", idx), lat1, v.lat1);
    chk($sformatf("v%0d_res1", idx), {16'h0, res1}, {16'h0, v.res});
    chk($sformatf("v%0d_high1", idx), {16'h0, high1}, {16'h0, v.high});
    chk($sformatf("v%0d_carry1", idx), {31'h0, carry1}, {31'h0, v.carry});
    chk($sformatf("v%0d_zero1", idx), {31'h0, zero1}, {31'h0, v.zero});
    chk($sformatf("v%0d_lat4", idx), lat4, v.lat4);
    chk($sformatf("v%0d_res4", idx), {16'h0, r4}, {16'h0, v.res});
    chk($sformatf("v%0d_high4", idx), {16'h0, h4}, {16'h0, v.high});
    chk($sformatf("v%0d_carry4", idx), {31'h0, c4}, {31'h0, v.carry});
    chk($sformatf("v%0d_zero4", idx), {31'h0, z4}, {31'h0, v.zero});
    @(posedge clock); #1;
    chk($sformatf("v%0d_ready_after", idx), {31'h0, ready1}, 32'h1);
    chk($sformatf("v%0d_valid_after", idx), {31'h0, valid1}, 32'h0);
  endtask

  initial begin
    //            op    a        b        res      high     c     z     lat1 lat4
    vecs[0]  = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b1, 0,  0};
    vecs[1]  = '{3'd1, 16'h0000, 16'h0001, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 0,  0};
    vecs[2]  = '{3'd4, 16'hF0F0, 16'hFF00, 16'h0FF0, 16'h0000, 1'b0, 1'b0, 0,  0};
    vecs[3]  = '{3'd5, 16'h1234, 16'h0010, 16'h2340, 16'h0001, 1'b0, 1'b0, 16, 4};
    vecs[4]  = '{3'd5, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b0, 16, 4};
    vecs[5]  = '{3'd6, 16'h8001, 16'h0001, 16'h0003, 16'h0000, 1'b0, 1'b0, 0,  0};
    vecs[6]  = '{3'd7, 16'h8001, 16'h0011, 16'hC000, 16'h0000, 1'b0, 1'b0, 0,  0};
    vecs[7]  = '{3'd6, 16'h8001, 16'h0000, 16'h8001, 16'h0000, 1'b0, 1'b0, 0,  0};
    vecs[8]  = '{3'd2, 16'hF0F0, 16'hFF00, 16'hF000, 16'h0000, 1'b0, 1'b0, 0,  0};
    vecs[9]  = '{3'd3, 16'h00F0, 16'h0F00, 16'h0FF0, 16'h0000, 1'b0, 1'b0, 0,  0};
    vecs[10] = '{3'd0, 16'h1234, 16'h1111, 16'h2345, 16'h0000, 1'b0, 1'b0, 0,  0};
    vecs[11] = '{3'd1, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b1, 0,  0};
    vecs[12] = '{3'd1, 16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 1'b1, 1'b0, 0,  0};
    vecs[13] = '{3'd5, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b1, 16, 4};
    vecs[14] = '{3'd7, 16'h0001, 16'h0004, 16'h1000, 16'h0000, 1'b0, 1'b0, 0,  0};
    vecs[15] = '{3'd6, 16'h1234, 16'h0004, 16'h2341, 16'h0000, 1'b0, 1'b0, 0,  0};

    reset = 1'b1; valid = 1'b0; op = 3'd0; src1 = '0; src2 = '0; rdy_in = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_ready1", {31'h0, ready1}, 32'h1);
    chk("rst_valid1", {31'h0, valid1}, 32'h0);
    chk("rst_res1", {16'h0, res1}, 32'h0);
    chk("rst_high1", {16'h0, high1}, 32'h0);
    chk("rst_carry1", {31'h0, carry1}, 32'h0);
    chk("rst_zero1", {31'h0, zero1}, 32'h0);
    chk("rst_ready4", {31'h0, ready4}, 32'h1);
    chk("rst_valid4", {31'h0, valid4}, 32'h0);

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Backpressure: hold DONE for 5 cycles, ignore a request pulse meanwhile.
    rdy_in = 1'b0;
    op = 3'd0; src1 = 16'h0007; src2 = 16'h0009; valid = 1'b1;
    @(posedge clock); #1;
    valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d_valid", c), {31'h0, valid1}, 32'h1);
      chk($sformatf("bp%0d_ready", c), {31'h0, ready1}, 32'h0);
      chk($sformatf("bp%0d_res", c), {16'h0, res1}, 32'h0010);
      chk($sformatf("bp%0d_carry", c), {31'h0, carry1}, 32'h0);
      if (c == 2) begin
        op = 3'd4; src1 = 16'hAAAA; src2 = 16'h5555; valid = 1'b1;
      end else begin
        valid = 1'b0;
      end
      @(posedge clock); #1;
    end
    valid = 1'b0;
    chk("bp_hold_res", {16'h0, res1}, 32'h0010);
    rdy_in = 1'b1;
    @(posedge clock); #1;
    chk("bp_drain_valid", {31'h0, valid1}, 32'h0);
    chk("bp_drain_ready", {31'h0, ready1}, 32'h1);
    @(posedge clock); #1;
    chk("bp_no_ghost_valid", {31'h0, valid1}, 32'h0);

    // Reset in the 7th cycle of a MUL.
    op = 3'd5; src1 = 16'h1234; src2 = 16'h0010; valid = 1'b1;
    @(posedge clock); #1;
    valid = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    chk("mr_busy_ready", {31'h0, ready1}, 32'h0);
    chk("mr_busy_valid", {31'h0, valid1}, 32'h0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("mr_valid", {31'h0, valid1}, 32'h0);
    chk("mr_ready", {31'h0, ready1}, 32'h1);
    chk("mr_res", {16'h0, res1}, 32'h0);
    chk("mr_high", {16'h0, high1}, 32'h0);
    chk("mr_carry", {31'h0, carry1}, 32'h0);
    chk("mr_zero", {31'h0, zero1}, 32'h0);
    chk("mr_res4", {16'h0, res4}, 32'h0);
    chk("mr_high4", {16'h0, high4}, 32'h0);
    run_vec(100, '{3'd0, 16'h0002, 16'h0003, 16'h0005, 16'h0000, 1'b0, 1'b0, 0, 0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
